arbitro_memoria_dados: RTL and testbench

- Two-port arbiter and sequencer for the 32-word data memory.
- Port 0 is the datapath load/store unit; port 1 is the auxiliary requester (program/data loader, debug).
- Grants one requester at a time with round-robin priority and drives the memory's ReadMem/WriteMem strobes and address for exactly one cycle per access.
- Captures read data and returns a one-cycle done pulse per access.

---
 rtl/arbitro_memoria_dados_if.sv | 56 +++++
 rtl/arbitro_memoria_dados.sv | 116 +++++++++++
 tb/tb_arbitro_memoria_dados.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_dados_if.sv
// Requester and memory bus bundle for the two-port data-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters
// and the memory that surround it.
interface arbitro_memoria_dados_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    // Port 0: datapath load/store unit
    logic              req0;
    logic              we0;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic [DATA_W-1:0] rdata0;
    logic              err0;

    // Port 1: auxiliary requester (loader, debug)
    logic              req1;
    logic              we1;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [DATA_W-1:0] rdata1;
    logic              err1;

    // Memory side
    logic              mem_ReadMem;
    logic              mem_WriteMem;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, done0, rdata0, err0,
        output gnt1, done1, rdata1, err1,
        output mem_ReadMem, mem_WriteMem, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, done0, rdata0, err0,
        input  gnt1, done1, rdata1, err1,
        input  mem_ReadMem, mem_WriteMem, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Two-port round-robin arbiter and sequencer for the data memory.
// Each access runs IDLE -> ACCESS -> CAPTURE. The strobes are high for one cycle, and done
// pulses for one cycle after the access returns to IDLE.
module arbitro_memoria_dados #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic                    clk,
    input logic                    reset_n,
    arbitro_memoria_dados_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StCapture = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;   // port number granted most recently
    logic   cur_port;     // port owning the in-flight access
    logic   cur_we;
    logic   cur_oor;

    logic              elig0;
    logic              elig1;
    logic              pick1;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    // Eligibility and winner selection for the IDLE decision edge
    always_comb begin
        // A port showing done this cycle may still be holding its old request.
        elig0     = bus.req0 & ~bus.done0;
        elig1     = bus.req1 & ~bus.done1;
        // On a tie, the port not granted last time wins.
        pick1     = elig1 & (~elig0 | ~last_grant);
        sel_we    = pick1 ? bus.we1    : bus.we0;
        sel_addr  = pick1 ? bus.addr1  : bus.addr0;
        sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
        sel_oor   = |sel_addr[DATA_W-1:ADDR_W];
    end

    assign bus.busy = (state != StIdle);

    // Sequencer FSM with registered grant, strobe, done and read-data outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= StIdle;
            last_grant       <= 1'b1;
            cur_port         <= 1'b0;
            cur_we           <= 1'b0;
            cur_oor          <= 1'b0;
            bus.gnt0         <= 1'b0;
            bus.gnt1         <= 1'b0;
            bus.done0        <= 1'b0;
            bus.done1        <= 1'b0;
            bus.err0         <= 1'b0;
            bus.err1         <= 1'b0;
            bus.rdata0       <= '0;
            bus.rdata1       <= '0;
            bus.mem_ReadMem  <= 1'b0;
            bus.mem_WriteMem <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (elig0 || elig1) begin
                        cur_port         <= pick1;
                        cur_we           <= sel_we;
                        cur_oor          <= sel_oor;
                        last_grant       <= pick1;
                        bus.gnt0         <= ~pick1;
                        bus.gnt1         <= pick1;
                        bus.mem_addr     <= sel_addr[ADDR_W-1:0];
                        bus.mem_wdata    <= sel_wdata;
                        // Out-of-range accesses run the same timeline with no strobe.
                        bus.mem_ReadMem  <= ~sel_we & ~sel_oor;
                        bus.mem_WriteMem <= sel_we & ~sel_oor;
                        state            <= StAccess;
                    end
                end
                StAccess: begin
                    bus.mem_ReadMem  <= 1'b0;
                    bus.mem_WriteMem <= 1'b0;
                    state            <= StCapture;
                end
                StCapture: begin
                    bus.gnt0 <= 1'b0;
                    bus.gnt1 <= 1'b0;
                    state    <= StIdle;
                    if (!cur_port) begin
                        bus.done0 <= 1'b1;
                        bus.err0  <= cur_oor;
                        if (cur_oor)      bus.rdata0 <= '0;
                        else if (!cur_we) bus.rdata0 <= bus.mem_rdata;
                    end else begin
                        bus.done1 <= 1'b1;
                        bus.err1  <= cur_oor;
                        if (cur_oor)      bus.rdata1 <= '0;
                        else if (!cur_we) bus.rdata1 <= bus.mem_rdata;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados with a 32-word registered-read memory model.
// Word i of the memory is preloaded with i+1.
module tb_arbitro_memoria_dados;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    arbitro_memoria_dados_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    arbitro_memoria_dados #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [32];

    // Memory model: it samples the strobes at the end of the ACCESS cycle and has a registered read.
    always @(posedge clk) begin
        if (bus.mem_WriteMem) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_ReadMem)  bus.mem_rdata     <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] order [4];
    int         n_grants;
    logic       prev0;
    logic       prev1;

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
        bus.mem_rdata = '0;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        check("idle_busy", bus.busy, 0);
        check("idle_strobes", {bus.mem_ReadMem, bus.mem_WriteMem}, 0);
        check("idle_gnt", {bus.gnt0, bus.gnt1}, 0);
        check("idle_rdata0", bus.rdata0, 0);

        // Port 0 reads word 3 (value 4).
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'd3;
        check("rd_c0_strobe", bus.mem_ReadMem, 0);
        step();
        check("rd_c1_read", bus.mem_ReadMem, 1);
        check("rd_c1_write", bus.mem_WriteMem, 0);
        check("rd_c1_addr", 32'(bus.mem_addr), 3);
        check("rd_c1_gnt", {bus.gnt0, bus.gnt1}, 2'b10);
        check("rd_c1_busy", bus.busy, 1);
        step();
        check("rd_c2_read", bus.mem_ReadMem, 0);
        check("rd_c2_done", bus.done0, 0);
        step();
        check("rd_c3_done", bus.done0, 1);
        check("rd_c3_rdata", bus.rdata0, 32'd4);
        check("rd_c3_err", bus.err0, 0);
        check("rd_c3_gnt", bus.gnt0, 0);
        bus.req0 = 0;
        step();
        check("rd_c4_done", bus.done0, 0);
        check("rd_c4_busy", bus.busy, 0);

        // Port 1 writes 0xDEADBEEF to word 10.
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'd10; bus.wdata1 = 32'hDEADBEEF;
        step();
        check("wr_c1_write", bus.mem_WriteMem, 1);
        check("wr_c1_read", bus.mem_ReadMem, 0);
        check("wr_c1_addr", 32'(bus.mem_addr), 10);
        check("wr_c1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("wr_c1_gnt", {bus.gnt0, bus.gnt1}, 2'b01);
        step();
        check("wr_c2_write", bus.mem_WriteMem, 0);
        step();
        check("wr_c3_done", bus.done1, 1);
        check("wr_c3_rdata", bus.rdata1, 0);
        check("wr_c3_err", bus.err1, 0);
        bus.req1 = 0;
        step();
        // Port 1 reads back word 10.
        bus.req1 = 1; bus.we1 = 0;
        step();
        check("rb_c1_read", bus.mem_ReadMem, 1);
        step();
        step();
        check("rb_c3_done", bus.done1, 1);
        check("rb_c3_rdata", bus.rdata1, 32'hDEADBEEF);
        bus.req1 = 0;
        step();

        // Reset is asserted mid-cycle and must clear the outputs without a clock edge.
        reset_n = 1'b0;
        #1;
        check("async_rdata1", bus.rdata1, 0);
        check("async_busy", bus.busy, 0);
        step();
        // Contention: both ports request from reset release.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'd3;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'd10;
        reset_n  = 1'b1;
        n_grants = 0;
        prev0    = 1'b0;
        prev1    = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            check("ct_gnt_overlap", 32'(bus.gnt0 & bus.gnt1), 0);
            if (bus.gnt0 && !prev0 && n_grants < 4) begin order[n_grants] = 2'd0; n_grants++; end
            if (bus.gnt1 && !prev1 && n_grants < 4) begin order[n_grants] = 2'd1; n_grants++; end
            prev0 = bus.gnt0;
            prev1 = bus.gnt1;
            if (c == 3) check("ct_done0_rdata", bus.rdata0, 32'd4);
            if (c == 6) check("ct_done1_rdata", bus.rdata1, 32'hDEADBEEF);
            if (c == 9)  bus.req0 = 0;
            if (c == 12) bus.req1 = 0;
        end
        check("ct_n_grants", n_grants, 4);
        check("ct_order0", 32'(order[0]), 0);
        check("ct_order1", 32'(order[1]), 1);
        check("ct_order2", 32'(order[2]), 0);
        check("ct_order3", 32'(order[3]), 1);
        step();
        check("ct_end_busy", bus.busy, 0);

        // Out-of-range read on port 0.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h20;
        step();
        check("oor_c1_strobes", {bus.mem_ReadMem, bus.mem_WriteMem}, 0);
        check("oor_c1_gnt", bus.gnt0, 1);
        step();
        check("oor_c2_strobes", {bus.mem_ReadMem, bus.mem_WriteMem}, 0);
        step();
        check("oor_c3_done", bus.done0, 1);
        check("oor_c3_err", bus.err0, 1);
        check("oor_c3_rdata", bus.rdata0, 0);
        bus.req0 = 0;
        step();
        check("oor_c4_err", bus.err0, 0);

        // Reset arrives during ACCESS: the access is abandoned, then a fresh read of word 0 runs.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'd0;
        step();
        check("ra_c1_read", bus.mem_ReadMem, 1);
        reset_n = 1'b0;
        #1;
        check("ra_strobe_drop", bus.mem_ReadMem, 0);
        check("ra_gnt_drop", bus.gnt0, 0);
        step();
        check("ra_no_done", bus.done0, 0);
        step();
        reset_n = 1'b1;
        step();
        check("ra_new_c1_read", bus.mem_ReadMem, 1);
        step();
        step();
        check("ra_new_done", bus.done0, 1);
        check("ra_new_rdata", bus.rdata0, 32'd1);
        bus.req0 = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
